// File: rtl/id_stage_1_if.sv
// Bundle of the memory port, the instruction hand-off to id_stage_2,
// the redirect request and the program counter for id_stage_1.
interface id_stage_1_if;
    logic        mem_read;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic [23:0] instruction;
    logic        instruction_valid;
    logic        instruction_finished;
    logic        jump_valid;
    logic [15:0] jump_address;
    logic [15:0] pc;

    // The fetch stage drives the memory request, the assembled word and the PC.
    modport master (
        output mem_read,
        output mem_addr,
        input  mem_data,
        input  mem_ready,
        output instruction,
        output instruction_valid,
        input  instruction_finished,
        input  jump_valid,
        input  jump_address,
        output pc
    );

    // The environment (memory, id_stage_2, branch unit) sees the mirror image.
    modport slave (
        input  mem_read,
        input  mem_addr,
        output mem_data,
        output mem_ready,
        input  instruction,
        input  instruction_valid,
        output instruction_finished,
        output jump_valid,
        output jump_address,
        input  pc
    );
endinterface

// File: rtl/id_stage_1.sv
// Instruction fetch/assembly stage. Reads three bytes, MSB first, from a
// byte-wide memory, holds the 24-bit word until id_stage_2 retires it,
// and owns the PC, including redirects that throw away partial fetches.
module id_stage_1 #(
    parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
    input logic         clk,
    input logic         reset_n,
    id_stage_1_if.master bus
);

    typedef enum logic [1:0] {
        FETCH0 = 2'd0,
        FETCH1 = 2'd1,
        FETCH2 = 2'd2,
        HOLD   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [23:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // State and datapath registers; reset lands on the first byte of RESET_VECTOR.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= FETCH0;
            pc_q    <= RESET_VECTOR;
            instr_q <= 24'h000000;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

    // Next-state logic: a redirect overrides everything, otherwise capture a byte
    // on each ready cycle, or wait in HOLD for the consumer to retire the word.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (bus.jump_valid) begin
            pc_d    = bus.jump_address;
            state_d = FETCH0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                FETCH0: begin
                    if (bus.mem_ready) begin
                        instr_d[23:16] = bus.mem_data;
                        pc_d           = pc_q + 16'd1;
                        state_d        = FETCH1;
                    end
                end
                FETCH1: begin
                    if (bus.mem_ready) begin
                        instr_d[15:8] = bus.mem_data;
                        pc_d          = pc_q + 16'd1;
                        state_d       = FETCH2;
                    end
                end
                FETCH2: begin
                    if (bus.mem_ready) begin
                        instr_d[7:0] = bus.mem_data;
                        pc_d         = pc_q + 16'd1;
                        valid_d      = 1'b1;
                        state_d      = HOLD;
                    end
                end
                HOLD: begin
                    if (bus.instruction_finished) begin
                        valid_d = 1'b0;
                        state_d = FETCH0;
                    end
                end
                default: begin
                    state_d = FETCH0;
                end
            endcase
        end
    end

    // Memory request is decoded from state so a new fetch starts the cycle HOLD ends.
    always_comb begin
        bus.mem_read = (state_q != HOLD);
        bus.mem_addr = pc_q;
    end

    assign bus.pc                = pc_q;
    assign bus.instruction       = instr_q;
    assign bus.instruction_valid = valid_q;

endmodule

// File: tb/tb_id_stage_1.sv
// Directed bench for id_stage_1: reset, fetch, wait states, hold/retire,
// mid-fetch redirect, jump priority, PC wrap and asynchronous reset.
module tb_id_stage_1;

    logic clk;
    logic reset_n;
    int   nCompared;
    int   nMismatched;

    id_stage_1_if bus ();

    id_stage_1 #(.RESET_VECTOR(16'h0000)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Small byte-wide memory image with hand-chosen contents.
    function automatic logic [7:0] memByte(input logic [15:0] a);
        case (a)
            16'h0000: memByte = 8'hA5;
            16'h0001: memByte = 8'h5C;
            16'h0002: memByte = 8'h3E;
            16'h0003: memByte = 8'h11;
            16'h0004: memByte = 8'h22;
            16'h0005: memByte = 8'h33;
            16'h0006: memByte = 8'h44;
            16'h0007: memByte = 8'h55;
            16'h1234: memByte = 8'h77;
            16'h1235: memByte = 8'h88;
            16'h1236: memByte = 8'h99;
            16'hFFFE: memByte = 8'hDE;
            16'hFFFF: memByte = 8'hAD;
            default:  memByte = 8'h00;
        endcase
    endfunction

    assign bus.mem_data = memByte(bus.mem_addr);

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bus.mem_ready = 1'b0;
        bus.instruction_finished = 1'b0;
        bus.jump_valid = 1'b0;
        bus.jump_address = 16'h0000;
        #2;
        nCompared++; if (bus.pc !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_pc: got %h expected 0000", bus.pc); end
        nCompared++; if (bus.instruction !== 24'h000000) begin nMismatched++; $display("[TB] FAIL reset_instr: got %h expected 000000", bus.instruction); end
        nCompared++; if (bus.instruction_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL reset_valid: got %b expected 0", bus.instruction_valid); end
        nCompared++; if (bus.mem_read !== 1'b1) begin nMismatched++; $display("[TB] FAIL reset_mem_read: got %b expected 1", bus.mem_read); end
        tick();
        tick();
        nCompared++; if (bus.pc !== 16'h0000) begin nMismatched++; $display("[TB] FAIL reset_held_pc: got %h expected 0000", bus.pc); end
    endtask

    task automatic test_fetch();
        @(negedge clk);
        reset_n = 1'b1;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        nCompared++; if (bus.instruction_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL fetch_valid_early: got %b expected 0", bus.instruction_valid); end
        tick();
        nCompared++; if (bus.instruction !== 24'hA55C3E) begin nMismatched++; $display("[TB] FAIL fetch_instr: got %h expected A55C3E", bus.instruction); end
        nCompared++; if (bus.instruction_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL fetch_valid: got %b expected 1", bus.instruction_valid); end
        nCompared++; if (bus.pc !== 16'h0003) begin nMismatched++; $display("[TB] FAIL fetch_pc: got %h expected 0003", bus.pc); end
        nCompared++; if (bus.mem_read !== 1'b0) begin nMismatched++; $display("[TB] FAIL fetch_mem_read: got %b expected 0", bus.mem_read); end
    endtask

    task automatic test_hold_retire();
        // mem_ready stays high in HOLD and must be ignored.
        for (int i = 0; i < 5; i++) begin
            tick();
            nCompared++; if (bus.instruction !== 24'hA55C3E || bus.instruction_valid !== 1'b1 || bus.pc !== 16'h0003)
                begin nMismatched++; $display("[TB] FAIL hold_stable[%0d]: got %h/%b/%h expected A55C3E/1/0003", i, bus.instruction, bus.instruction_valid, bus.pc); end
        end
        bus.instruction_finished = 1'b1;
        tick();
        bus.instruction_finished = 1'b0;
        bus.mem_ready = 1'b0;
        nCompared++; if (bus.instruction_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL retire_valid: got %b expected 0", bus.instruction_valid); end
        nCompared++; if (bus.mem_read !== 1'b1) begin nMismatched++; $display("[TB] FAIL retire_mem_read: got %b expected 1", bus.mem_read); end
        nCompared++; if (bus.mem_addr !== 16'h0003) begin nMismatched++; $display("[TB] FAIL retire_mem_addr: got %h expected 0003", bus.mem_addr); end
        nCompared++; if (bus.instruction !== 24'hA55C3E) begin nMismatched++; $display("[TB] FAIL retire_instr_kept: got %h expected A55C3E", bus.instruction); end
    endtask

    task automatic test_wait_states();
        logic        readyPat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [15:0] expPc    [6] = '{16'h0004, 16'h0004, 16'h0004, 16'h0005, 16'h0005, 16'h0006};
        for (int i = 0; i < 6; i++) begin
            bus.mem_ready = readyPat[i];
            tick();
            nCompared++; if (bus.pc !== expPc[i]) begin nMismatched++; $display("[TB] FAIL wait_pc[%0d]: got %h expected %h", i, bus.pc, expPc[i]); end
            if (i == 0) begin
                nCompared++; if (bus.instruction !== 24'h115C3E) begin nMismatched++; $display("[TB] FAIL wait_first_byte: got %h expected 115C3E", bus.instruction); end
            end
            if (i == 4) begin
                nCompared++; if (bus.instruction_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL wait_valid_early: got %b expected 0", bus.instruction_valid); end
            end
        end
        nCompared++; if (bus.instruction !== 24'h112233) begin nMismatched++; $display("[TB] FAIL wait_instr: got %h expected 112233", bus.instruction); end
        nCompared++; if (bus.instruction_valid !== 1'b1) begin nMismatched++; $display("[TB] FAIL wait_valid: got %b expected 1", bus.instruction_valid); end
        bus.mem_ready = 1'b0;
        bus.instruction_finished = 1'b1;
        tick();
        bus.instruction_finished = 1'b0;
    endtask

    task automatic test_redirect();
        bus.mem_ready = 1'b1;
        tick();
        nCompared++; if (bus.instruction !== 24'h442233) begin nMismatched++; $display("[TB] FAIL redir_pre_instr: got %h expected 442233", bus.instruction); end
        bus.jump_valid = 1'b1;
        bus.jump_address = 16'h1234;
        tick();
        bus.jump_valid = 1'b0;
        nCompared++; if (bus.pc !== 16'h1234) begin nMismatched++; $display("[TB] FAIL redir_pc: got %h expected 1234", bus.pc); end
        nCompared++; if (bus.mem_addr !== 16'h1234) begin nMismatched++; $display("[TB] FAIL redir_mem_addr: got %h expected 1234", bus.mem_addr); end
        nCompared++; if (bus.instruction !== 24'h442233) begin nMismatched++; $display("[TB] FAIL redir_byte_dropped: got %h expected 442233", bus.instruction); end
        nCompared++; if (bus.instruction_valid !== 1'b0) begin nMismatched++; $display("[TB] FAIL redir_valid: got %b expected 0", bus.instruction_valid); end
        tick();
        nCompared++; if (bus.instruction !== 24'h772233) begin nMismatched++; $display("[TB] FAIL redir_first_capture: got %h expected 772233", bus.instruction); end
        tick();
        tick();
        nCompared++; if (bus.instruction !== 24'h778899) begin nMismatched++; $display("[TB] FAIL redir_instr: got %h expected 778899", bus.instruction); end
        nCompared++; if (bus.pc !== 16'h1237) begin nMismatched++; $display("[TB] FAIL redir_end_pc: got %h expected 1237", bus.pc); end
    endtask

    task automatic test_priority_and_wrap();
        logic [15:0] expAddr [3] = '{16'hFFFE, 16'hFFFF, 16'h0000};
        bus.jump_valid = 1'b1;
        bus.jump_address = 16'hFFFE;
        bus.instruction_finished = 1'b1;
        tick();
        bus.jump_valid = 1'b0;
        bus.instruction_finished = 1'b0;
        nCompared++; if (bus.pc !== 16'hFFFE) begin nMismatched++; $display("[TB] FAIL prio_pc: got %h expected FFFE", bus.pc); end
        nCompared++; if (bus.instruction_valid !== 1'b0 || bus.mem_read !== 1'b1)
            begin nMismatched++; $display("[TB] FAIL prio_state: got valid %b read %b expected 0/1", bus.instruction_valid, bus.mem_read); end
        for (int i = 0; i < 3; i++) begin
            nCompared++; if (bus.mem_addr !== expAddr[i]) begin nMismatched++; $display("[TB] FAIL wrap_addr[%0d]: got %h expected %h", i, bus.mem_addr, expAddr[i]); end
            tick();
        end
        nCompared++; if (bus.instruction !== 24'hDEADA5) begin nMismatched++; $display("[TB] FAIL wrap_instr: got %h expected DEADA5", bus.instruction); end
        nCompared++; if (bus.pc !== 16'h0001) begin nMismatched++; $display("[TB] FAIL wrap_pc: got %h expected 0001", bus.pc); end
    endtask

    task automatic test_async_reset();
        bus.mem_ready = 1'b0;
        bus.instruction_finished = 1'b1;
        tick();
        bus.instruction_finished = 1'b0;
        bus.mem_ready = 1'b1;
        tick();
        tick();
        nCompared++; if (bus.pc !== 16'h0003 || bus.instruction !== 24'h5C3EA5)
            begin nMismatched++; $display("[TB] FAIL areset_pre: got %h/%h expected 0003/5C3EA5", bus.pc, bus.instruction); end
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        nCompared++; if (bus.pc !== 16'h0000) begin nMismatched++; $display("[TB] FAIL areset_pc: got %h expected 0000", bus.pc); end
        nCompared++; if (bus.instruction !== 24'h000000) begin nMismatched++; $display("[TB] FAIL areset_instr: got %h expected 000000", bus.instruction); end
        nCompared++; if (bus.instruction_valid !== 1'b0 || bus.mem_read !== 1'b1)
            begin nMismatched++; $display("[TB] FAIL areset_flags: got valid %b read %b expected 0/1", bus.instruction_valid, bus.mem_read); end
        @(negedge clk);
        reset_n = 1'b1;
        nCompared++; if (bus.mem_addr !== 16'h0000) begin nMismatched++; $display("[TB] FAIL areset_first_addr: got %h expected 0000", bus.mem_addr); end
        tick();
        tick();
        tick();
        nCompared++; if (bus.instruction !== 24'hA55C3E || bus.instruction_valid !== 1'b1)
            begin nMismatched++; $display("[TB] FAIL areset_refetch: got %h/%b expected A55C3E/1", bus.instruction, bus.instruction_valid); end
    endtask

    // Run every scenario in order, then report.
    initial begin
        nCompared = 0;
        nMismatched = 0;
        test_reset();
        test_fetch();
        test_hold_retire();
        test_wait_states();
        test_redirect();
        test_priority_and_wrap();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

    // Safety net so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/id_stage_1.md
# id_stage_1

Instruction fetch/assembly stage directly upstream of `id_stage_2`. It reads the 24-bit instruction stream one byte per transfer from the byte-wide memory port and assembles each instruction most-significant byte first. It then holds the assembled word stable on `instruction` until `id_stage_2` reports `instruction_finished`. It owns the program counter and accepts control-flow redirects that flush any partially assembled instruction.

## Interface
- `RESET_VECTOR`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `mem_read`  out  1  byte read request.
- `mem_addr`  out  16  byte address, always equal to `pc`.
- `mem_data`  in  8  read data, valid when `mem_ready`=1.
- `mem_ready`  in  1  read completes this cycle.
- `instruction`  out  24  assembled instruction to `id_stage_2`.
- `instruction_valid`  out  1  `instruction` is complete and held.
- `instruction_finished`  in  1  from `id_stage_2`: current instruction retired.
- `jump_valid`  in  1  redirect request.
- `jump_address`  in  16  redirect target.
- `pc`  out  16  address of the next byte to fetch.

## Operation
- Registered FSM with states `FETCH0`, `FETCH1`, `FETCH2` and `HOLD`.
- Reset values:
  - state = `FETCH0`, `pc` = `RESET_VECTOR`.
  - `instruction` = 24'h000000, `instruction_valid` = 0, `mem_read` = 1 (combinational from state).
- `mem_read` = 1 in the `FETCHn` states and 0 in `HOLD`.
- `mem_addr` = `pc`, combinationally.
- In `FETCHn`, a cycle with `mem_ready`=1 captures the byte and increments `pc`:
  - `FETCH0`: `mem_data` is written to `instruction[23:16]`; next state `FETCH1`.
  - `FETCH1`: `mem_data` is written to `instruction[15:8]`; next state `FETCH2`.
  - `FETCH2`: `mem_data` is written to `instruction[7:0]`, `instruction_valid` is set; next state `HOLD`.
- In a `FETCHn` state with `mem_ready`=0, all state and registers hold.
- `HOLD`:
  - `instruction` and `instruction_valid` stay stable.
  - `instruction_finished`=1 clears `instruction_valid`; next state `FETCH0`.
  - `instruction` keeps its old value until overwritten by the next fetch.
- `instruction_finished` is ignored in every state other than `HOLD`.
- Redirect: `jump_valid`=1 in any state does all of the following on the next edge:
  - `pc` = `jump_address`, state = `FETCH0`, `instruction_valid` = 0.
  - Any partially assembled bytes are discarded.
- Priority: `reset_n` > `jump_valid` > `mem_ready` / `instruction_finished`.
  - A byte returned in the same cycle as `jump_valid` is dropped and `pc` does not increment.
  - `jump_valid` and `instruction_finished` together in `HOLD` resolve to the jump.
- `pc` arithmetic is 16-bit modulo; 16'hFFFF + 1 = 16'h0000. Instructions may straddle the wrap.
- No alignment is enforced; any `jump_address` is legal.

## Timing
- All outputs except `mem_read`/`mem_addr` are registered.
- Fetch latency with zero memory wait states:
  - bytes are captured at edges 1, 2 and 3 after entering `FETCH0`;
  - `instruction_valid`=1 from edge 3.
- Each wait cycle (`mem_ready`=0) adds exactly one cycle.
- Retire: `instruction_finished` sampled at edge N in `HOLD` gives `instruction_valid`=0 and `mem_read`=1 after edge N. The next fetch begins in that cycle.
- Minimum throughput is 4 cycles per instruction (3 fetch + 1 hold). There is no prefetch.
- Redirect: `jump_valid` sampled at edge N makes `mem_addr` = `jump_address` in the cycle after edge N.
- Asserting `reset_n`=0 mid-fetch immediately (asynchronously) forces all reset values, including `instruction_valid`=0.
- The first fetch after `reset_n` rises uses `RESET_VECTOR`.

## Test plan
- Reset release:
  - Stimulus: memory returns bytes A5, 5C, 3E at 0x0000..0x0002 with no waits.
  - Response: `instruction`=24'hA55C3E and `instruction_valid`=1 three edges after reset; `pc`=0x0003; `mem_read`=0.
- Wait states:
  - Stimulus: `mem_ready` pattern 1,0,0,1,0,1.
  - Response: valid after 6 edges; bytes land in order; `pc` increments only on ready cycles.
- Hold/retire:
  - Stimulus: hold `instruction_finished`=0 for 5 cycles, then pulse it.
  - Response: `instruction` stable for all 5 cycles; `instruction_valid` falls on the next edge; `mem_addr`=0x0003 with `mem_read`=1.
- Mid-fetch redirect:
  - Stimulus: `jump_valid`=1 with `jump_address`=0x1234 in `FETCH1`, in the same cycle as `mem_ready`=1.
  - Response: byte dropped; `pc`=0x1234; the next capture goes to `instruction[23:16]`.
- Wrap-around:
  - Stimulus: jump to 0xFFFE; fetch 3 bytes.
  - Response: reads from 0xFFFE, 0xFFFF, 0x0000; final `pc`=0x0001.
- Async reset and priority:
  - Stimulus 1: pull `reset_n` low between edges in `FETCH2`.
  - Response 1: outputs go to reset values immediately, with `pc`=`RESET_VECTOR`.
  - Stimulus 2: `jump_valid` and `instruction_finished` together in `HOLD`.
  - Response 2: the jump wins.
